// File: rtl/chip_select_controller.sv
// chip_select_controller: sequences a 3-to-8 active-low chip-select decoder for 68000 bus cycles
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   as_n, uds_n, lds_n, rw      CPU bus strobes and direction (1 = read)
//   addr_hi                     A23..A21, selects one of 8 regions
//   cfg_we, cfg_sel, cfg_wait,
//   cfg_en, cfg_wp              per-region configuration write port
//   cfg_rdata                   {en, wp, wait} of region cfg_sel (combinational)
//   dec_a, dec_e1_n, dec_e2_n,
//   dec_e3                      decoder select and enables (registered)
//   dtack_n, berr_n, busy       cycle termination and activity (registered)
module chip_select_controller #(
    parameter int WAIT_W       = 4,
    parameter int DEFAULT_WAIT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              as_n,
    input  logic              uds_n,
    input  logic              lds_n,
    input  logic              rw,
    input  logic [2:0]        addr_hi,
    input  logic              cfg_we,
    input  logic [2:0]        cfg_sel,
    input  logic [WAIT_W-1:0] cfg_wait,
    input  logic              cfg_en,
    input  logic              cfg_wp,
    output logic [WAIT_W+1:0] cfg_rdata,
    output logic [2:0]        dec_a,
    output logic              dec_e1_n,
    output logic              dec_e2_n,
    output logic              dec_e3,
    output logic              dtack_n,
    output logic              berr_n,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, WAIT, ACK, BERR} state_t;
    state_t            state;
    logic [WAIT_W-1:0] count;
    logic [7:0]        en;
    logic [7:0]        wp;
    logic [WAIT_W-1:0] wt [8];
    logic              req;
    assign req       = !as_n && (!uds_n || !lds_n);
    assign cfg_rdata = {en[cfg_sel], wp[cfg_sel], wt[cfg_sel]};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en <= '1;
            wp <= '0;
            for (int i = 0; i < 8; i++) wt[i] <= WAIT_W'(DEFAULT_WAIT);
        end else if (cfg_we) begin
            en[cfg_sel] <= cfg_en;
            wp[cfg_sel] <= cfg_wp;
            wt[cfg_sel] <= cfg_wait;
        end
    end
    // a request on the same edge as a config write sees the pre-edge region values
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            dec_a    <= '0;
            dec_e1_n <= 1'b1;
            dec_e2_n <= 1'b1;
            dec_e3   <= 1'b0;
            dtack_n  <= 1'b1;
            berr_n   <= 1'b1;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    busy <= 1'b1;
                    if (!en[addr_hi] || (wp[addr_hi] && !rw)) begin
                        state  <= BERR;
                        berr_n <= 1'b0;
                    end else begin
                        state    <= WAIT;
                        dec_a    <= addr_hi;
                        dec_e1_n <= 1'b0;
                        dec_e2_n <= 1'b0;
                        dec_e3   <= 1'b1;
                        count    <= wt[addr_hi];
                    end
                end
                WAIT: if (as_n) begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    dec_e1_n <= 1'b1;
                    dec_e2_n <= 1'b1;
                    dec_e3   <= 1'b0;
                    dtack_n  <= 1'b1;
                end else if (count != '0) begin
                    count <= count - 1'b1;
                end else begin
                    state   <= ACK;
                    dtack_n <= 1'b0;
                end
                ACK: if (as_n) begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    dec_e1_n <= 1'b1;
                    dec_e2_n <= 1'b1;
                    dec_e3   <= 1'b0;
                    dtack_n  <= 1'b1;
                end
                BERR: if (as_n) begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    berr_n <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/chip_select_controller.md
Name: chip_select_controller

Overview:
- Sequences the 3-to-8 active-low chip-select decoder for 68000 bus cycles.
- Samples address strobe, data strobes, R/W and address bits A23..A21, and drives the decoder select and enable inputs.
- Inserts per-region programmable wait states, then returns DTACK, or BERR for disabled or write-protected regions.
- Sits between the CPU bus interface and the decoder that fans out to memory and peripheral chip selects.

Parameters:
- WAIT_W, 4, width of per-region wait-state count.
- DEFAULT_WAIT, 2, reset wait-state count loaded into all 8 regions.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- as_n  input  1  address strobe, active low; already synchronous to clk.
- uds_n  input  1  upper data strobe, active low.
- lds_n  input  1  lower data strobe, active low.
- rw  input  1  1 = read, 0 = write.
- addr_hi  input  3  A23..A21, region index.
- cfg_we  input  1  config write strobe.
- cfg_sel  input  3  region addressed by config write/read.
- cfg_wait  input  WAIT_W  wait-state count to write.
- cfg_en  input  1  region enable bit to write.
- cfg_wp  input  1  region write-protect bit to write.
- cfg_rdata  output  WAIT_W+2  {en, wp, wait} of region cfg_sel; combinational.
- dec_a  output  3  decoder select.
- dec_e1_n  output  1  decoder enable, active low.
- dec_e2_n  output  1  decoder enable, active low.
- dec_e3  output  1  decoder enable, active high.
- dtack_n  output  1  data transfer acknowledge, active low.
- berr_n  output  1  bus error, active low.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- All outputs except cfg_rdata are registered.
- Reset (async, any state, including mid-cycle) forces:
  - state = IDLE, dec_a = 0, dec_e1_n = 1, dec_e2_n = 1, dec_e3 = 0, dtack_n = 1, berr_n = 1, busy = 0, count = 0.
  - All 8 regions to en = 1, wp = 0, wait = DEFAULT_WAIT.
- Request condition: as_n == 0 && (uds_n == 0 || lds_n == 0).
- Config:
  - On edge with cfg_we, region cfg_sel takes {cfg_en, cfg_wp, cfg_wait}.
  - A request sampled on the same edge uses the pre-edge register value.
  - The count already loaded for an in-flight cycle is never altered by a config write.
- FSM states: IDLE, WAIT, ACK, BERR.
- IDLE, on the edge sampling a request:
  - Latch region r = addr_hi.
  - If en[r] == 0, or (wp[r] == 1 and rw == 0): go to BERR with berr_n <= 0; decoder enables stay inactive.
  - Otherwise: go to WAIT with dec_a <= r, dec_e1_n <= 0, dec_e2_n <= 0, dec_e3 <= 1, count <= wait[r].
- WAIT:
  - If as_n == 1 (abort): go to IDLE, all enables and dtack_n deasserted on that edge.
  - Else if count != 0: count <= count - 1.
  - Else (count == 0): dtack_n <= 0, go to ACK.
- Latency: request sampled at edge k gives dtack_n low from edge k+1+W, where W = wait[r].
  - W = 0 gives 1 cycle.
  - W = 2^WAIT_W - 1 is the maximum, with no wrap.
- ACK:
  - Hold dtack_n = 0 and decoder enables while as_n == 0.
  - On the edge sampling as_n == 1: dtack_n <= 1, dec_e1_n <= 1, dec_e2_n <= 1, dec_e3 <= 0, go to IDLE.
  - dec_a holds its last value.
- BERR: hold berr_n = 0 until as_n sampled 1, then berr_n <= 1 and go to IDLE.
- Back-to-back cycles: a new request is accepted no earlier than the edge after the return to IDLE.
  - as_n must be seen high for at least one edge between cycles.
- dtack_n and berr_n are never low simultaneously.
- Decoder enables are never active outside WAIT/ACK.
- as_n low with both data strobes high: no request, remain IDLE.
- addr_hi, rw and strobes changing after acceptance have no effect until IDLE.

Test Plan:
- Reset then read with addr_hi = 3'b010, W = 2 → dec_a = 2 with enables active at edge k; dtack_n low at edge k+3; after as_n high, all deasserted next edge; busy tracks accordingly.
- cfg write region 5 with wait = 0, then read addr_hi = 3'b101 → dtack_n low at edge k+1. cfg write region 6 with wait = 15, then read addr_hi = 3'b110 → dtack_n low at edge k+16. cfg_rdata for region 5 reads {1, 0, 4'd0}.
- Region 3 with en = 0, access addr_hi = 3'b011 → berr_n low at edge k, enables stay inactive, dtack_n stays 1. Region 4 with wp = 1: write (rw = 0) gives berr_n low; read gives dtack_n low after default 2 waits.
- Abort: as_n rises during WAIT with W = 5 after 2 cycles → return to IDLE on that edge, dtack_n never asserts, enables deassert.
- rst pulsed mid-ACK → outputs immediately return to reset values without waiting for a clock; cfg regions revert to en = 1, wp = 0, wait = 2.
- Same-edge cfg_we to region 1 (wait 7) and request to region 1 (old wait 2) → dtack_n low at edge k+3; next access to region 1 → dtack_n low at edge k+8.
